// File: rtl/fixed_divider_if.sv
`default_nettype none
// ============================================================================
// fixed_divider_if : operand/result valid-ready bundle for fixed_divider
// Rev 1.0
// ============================================================================
interface fixed_divider_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, div_by_zero, overflow
  );
endinterface
`default_nettype wire

// File: rtl/fixed_divider.sv
`default_nettype none
// ============================================================================
// fixed_divider : sequential signed Qm.n restoring divider, one bit per clock
// Rev 1.0
// ============================================================================
module fixed_divider #(
  parameter int WIDTH      = 32,
  parameter int FRAC_WIDTH = 30
) (
  input  wire logic      clk,
  input  wire logic      reset,
  fixed_divider_if.slave bus
);
  localparam int c_iter = WIDTH + FRAC_WIDTH;
  localparam int c_cw   = $clog2(c_iter + 1);
  localparam logic [c_cw-1:0]   c_last    = c_cw'(c_iter - 1);
  localparam logic [c_cw-1:0]   c_one     = c_cw'(1);
  localparam logic [WIDTH-1:0]  c_max     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]  c_min     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [c_iter-1:0] c_pos_lim = c_iter'(c_max);
  localparam logic [c_iter-1:0] c_neg_lim = c_iter'(c_min);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_sign;
  logic [WIDTH-1:0]   r_num;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH-1:0]   r_rem;
  logic [c_iter-2:0]  r_q;
  logic [c_cw-1:0]    r_cnt;
  logic [WIDTH-1:0]   r_quot;
  logic               r_dbz;
  logic               r_ovf;

  logic               w_dvs_zero;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_next;
  logic [c_iter-1:0]  w_q_next;
  logic               w_last;
  logic [WIDTH-1:0]   w_res;
  logic               w_res_ov;

  // Unsigned magnitudes: the most-negative operand maps to exactly 2^(WIDTH-1)
  assign w_mag_a    = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign w_mag_b    = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
  assign w_dvs_zero = (bus.divisor == '0);

  // r_num shifts out the dividend MSB first, then zeros for the fractional extension
  assign w_rem_sh   = {r_rem, r_num[WIDTH-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_next = w_ge ? (w_rem_sh[WIDTH-1:0] - r_dvs) : w_rem_sh[WIDTH-1:0];
  assign w_q_next   = {r_q, w_ge};
  assign w_last     = (r_cnt == c_last);

  always_comb begin
    w_res    = w_q_next[WIDTH-1:0];
    w_res_ov = 1'b0;
    if (!r_sign) begin
      if (w_q_next > c_pos_lim) begin
        w_res    = c_max;
        w_res_ov = 1'b1;
      end
    end else if (w_q_next > c_neg_lim) begin
      w_res    = c_min;
      w_res_ov = 1'b1;
    end else begin
      w_res = -w_q_next[WIDTH-1:0];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.in_valid) w_next = w_dvs_zero ? DONE : CALC;
      CALC: if (w_last) w_next = DONE;
      DONE: if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sign <= 1'b0;
      r_num  <= '0;
      r_dvs  <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_dbz  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_sign <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            r_num  <= w_mag_a;
            r_dvs  <= w_mag_b;
            r_rem  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            if (w_dvs_zero) begin
              r_quot <= bus.dividend[WIDTH-1] ? c_min : c_max;
              r_dbz  <= 1'b1;
              r_ovf  <= 1'b1;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next[c_iter-2:0];
          r_num <= {r_num[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + c_one;
          if (w_last) begin
            r_quot <= w_res;
            r_dbz  <= 1'b0;
            r_ovf  <= w_res_ov;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == IDLE);
  assign bus.out_valid   = (r_state == DONE);
  assign bus.quotient    = r_quot;
  assign bus.div_by_zero = r_dbz;
  assign bus.overflow    = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_fixed_divider.sv
`default_nettype none
// ============================================================================
// tb_fixed_divider : vector table, reference model and scoreboard for fixed_divider
// Rev 1.0
// ============================================================================
module tb_fixed_divider;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fixed_divider_if #(.WIDTH(W)) bus ();

  fixed_divider #(.WIDTH(W), .FRAC_WIDTH(30)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] q;
    logic        dz;
    logic        ov;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        dz;
    logic        ov;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer division of the Q-scaled magnitudes, then saturate
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint unsigned ma, mb, q;
    e.lat = 63;
    e.dz  = 1'b0;
    e.ov  = 1'b0;
    if (b == 32'd0) begin
      e.q   = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      e.dz  = 1'b1;
      e.ov  = 1'b1;
      e.lat = 1;
      return e;
    end
    ma = a[31] ? (64'd4294967296 - {32'd0, a}) : {32'd0, a};
    mb = b[31] ? (64'd4294967296 - {32'd0, b}) : {32'd0, b};
    q  = (ma << 30) / mb;
    if (!(a[31] ^ b[31])) begin
      if (q > 64'h7FFF_FFFF) begin e.q = 32'h7FFF_FFFF; e.ov = 1'b1; end
      else                         e.q = 32'(q);
    end else begin
      if (q > 64'h8000_0000) begin e.q = 32'h8000_0000; e.ov = 1'b1; end
      else                         e.q = 32'(64'd0 - q);
    end
    return e;
  endfunction

  task automatic start(input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    check("in_ready before accept", 32'(bus.in_ready), 32'd1);
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    sb.push_back(e);
    tick();
    bus.in_valid = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
  endtask

  task automatic collect(input string tag);
    int   lat = 1;
    logic busy_ready = 1'b0;
    exp_t e;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) busy_ready = 1'b1;
      tick();
      lat++;
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got result with no expected entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " quotient"}, bus.quotient, e.q);
      check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(e.dz));
      check({tag, " overflow"}, 32'(bus.overflow), 32'(e.ov));
      check({tag, " latency"}, 32'(lat), 32'(e.lat));
      check({tag, " in_ready while busy"}, 32'(busy_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, " out_valid after handshake"}, 32'(bus.out_valid), 32'd0);
    check({tag, " in_ready after handshake"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[9];
    exp_t e;
    logic [31:0] ra, rb;
    logic [31:0] held_q;
    int n;
    logic stale;

    tbl[0] = '{32'h2000_0000, 32'h4000_0000, 32'h2000_0000, 1'b0, 1'b0};
    tbl[1] = '{32'h1000_0000, 32'h3000_0000, 32'h1555_5555, 1'b0, 1'b0};
    tbl[2] = '{32'hE000_0000, 32'h4000_0000, 32'hE000_0000, 1'b0, 1'b0};
    tbl[3] = '{32'h4000_0000, 32'h2000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
    tbl[4] = '{32'hC000_0000, 32'h2000_0000, 32'h8000_0000, 1'b0, 1'b0};
    tbl[5] = '{32'h8000_0000, 32'hC000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
    tbl[6] = '{32'h2000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[7] = '{32'hA000_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1};
    tbl[8] = '{32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) tick();
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset quotient", bus.quotient, 32'd0);
    check("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
    check("reset overflow", 32'(bus.overflow), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      e.q   = tbl[i].q;
      e.dz  = tbl[i].dz;
      e.ov  = tbl[i].ov;
      e.lat = (tbl[i].b == 32'd0) ? 1 : 63;
      start(tbl[i].a, tbl[i].b, e);
      collect($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      start(ra, rb, model(ra, rb));
      collect($sformatf("rnd%0d", i));
    end

    // Backpressure: result must hold while in_valid toggles with junk operands
    start(32'h1000_0000, 32'h3000_0000, model(32'h1000_0000, 32'h3000_0000));
    n = 0;
    while (!bus.out_valid && n < 200) begin
      tick();
      n++;
    end
    check("bp out_valid", 32'(bus.out_valid), 32'd1);
    e = sb.pop_front();
    held_q = e.q;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.dividend = 32'h7000_0000;
      bus.divisor  = 32'h0000_0001;
      check($sformatf("bp hold%0d quotient", i), bus.quotient, held_q);
      check($sformatf("bp hold%0d flags", i),
            32'({bus.out_valid, bus.in_ready, bus.div_by_zero, bus.overflow}), 32'b1000);
      tick();
    end
    bus.out_ready = 1'b1;
    bus.dividend  = 32'h2000_0000;
    bus.divisor   = 32'h4000_0000;
    sb.push_back(model(32'h2000_0000, 32'h4000_0000));
    tick();
    bus.out_ready = 1'b0;
    check("b2b out_valid dropped", 32'(bus.out_valid), 32'd0);
    check("b2b in_ready raised", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("b2b accepted next edge", 32'(bus.in_ready), 32'd0);
    collect("b2b");

    // Reset in the middle of a division
    start(32'h4000_0000, 32'h2000_0000, model(32'h4000_0000, 32'h2000_0000));
    repeat (20) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    check("midreset in_ready", 32'(bus.in_ready), 32'd1);
    check("midreset out_valid", 32'(bus.out_valid), 32'd0);
    check("midreset quotient", bus.quotient, 32'd0);
    stale = 1'b0;
    for (int i = 0; i < 70; i++) begin
      if (bus.out_valid) stale = 1'b1;
      tick();
    end
    check("midreset no stale result", 32'(stale), 32'd0);
    start(32'h4000_0000, 32'h4000_0000, model(32'h4000_0000, 32'h4000_0000));
    collect("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
